// File: rtl/fft_sink_framer.sv
// fft_sink_framer: buffers ADC samples and frames them into Avalon-ST packets for an FFT sink.
// Define FFT_FRAMER_OVF_CNT_EN to add the saturating ovf_count output.
module fft_sink_framer #(
   parameter int DEPTH = 1024,
   parameter int ADC_W = 12
) (
   input  logic             clock50,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [10:0]      fftpts_cfg,
   input  logic             inverse_cfg,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic             src_valid,
   input  logic             src_ready,
   output logic             src_sop,
   output logic             src_eop,
   output logic [1:0]       src_error,
   output logic [47:0]      src_data,
   output logic             overflow,
   input  logic             clr_ovf,
   output logic             cfg_err,
   output logic             busy
`ifdef FFT_FRAMER_OVF_CNT_EN
   ,
   output logic [15:0]      ovf_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [ADC_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic [10:0] beat_cnt, fft_lat;
   logic inv_lat, pop, drop, wr, cfg_ok, start;
   logic [ADC_W-1:0] head;
   logic [17:0] re;
   assign pop = src_valid && src_ready;
   assign drop = adc_valid && level == LW'(DEPTH) && !pop;
   assign wr = adc_valid && !drop;
   assign cfg_ok = fftpts_cfg >= 11'd8 && 32'(fftpts_cfg) <= DEPTH && (fftpts_cfg & (fftpts_cfg - 11'd1)) == 11'd0;
   assign head = mem[rd_ptr];
   // offset binary to two's complement, left-justified
   assign re = 18'({~head[ADC_W-1], head[ADC_W-2:0]}) << (18 - ADC_W);
   assign busy = state == SEND;
   assign src_valid = busy;
   assign src_sop = busy && beat_cnt == 11'd0;
   assign src_eop = busy && beat_cnt == fft_lat - 11'd1;
   assign src_error = 2'b00;
   assign src_data = busy ? {re, 18'd0, fft_lat, inv_lat} : 48'd0;
   always_ff @(posedge clock50)
      if (wr) mem[wr_ptr] <= adc_data;
   always_ff @(posedge clock50 or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         overflow <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
         level <= level + LW'(wr) - LW'(pop);
         overflow <= drop || (overflow && !clr_ovf);
         cfg_err <= !cfg_ok;
      end
   always_comb begin
      state_nxt = state;
      start = 1'b0;
      if (state == IDLE) begin
         start = enable && !cfg_err && cfg_ok && 32'(level) >= 32'(fftpts_cfg);
         state_nxt = start ? SEND : IDLE;
      end else if (pop && src_eop) state_nxt = IDLE;
   end
   always_ff @(posedge clock50 or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   // packet parameters are frozen at the start edge
   always_ff @(posedge clock50 or negedge reset_n)
      if (!reset_n) begin
         beat_cnt <= '0;
         fft_lat <= '0;
         inv_lat <= 1'b0;
      end else if (start) begin
         beat_cnt <= '0;
         fft_lat <= fftpts_cfg;
         inv_lat <= inverse_cfg;
      end else if (pop) beat_cnt <= src_eop ? 11'd0 : beat_cnt + 11'd1;
`ifdef FFT_FRAMER_OVF_CNT_EN
   always_ff @(posedge clock50 or negedge reset_n)
      if (!reset_n) ovf_count <= '0;
      else if (clr_ovf) ovf_count <= {15'd0, drop};
      else if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
`endif
endmodule

// File: tb/tb_fft_sink_framer.sv
// tb_fft_sink_framer: directed self-checking bench for fft_sink_framer with DEPTH=16.
// Exercises ovf_count too when FFT_FRAMER_OVF_CNT_EN is defined.
module tb_fft_sink_framer;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, inverse_cfg = 1'b1, adc_valid = 1'b0;
   logic src_ready = 1'b1, clr_ovf = 1'b0;
   logic [10:0] fftpts_cfg = 11'd8;
   logic [11:0] adc_data = 12'd0;
   logic src_valid, src_sop, src_eop, overflow, cfg_err, busy;
   logic [1:0] src_error;
   logic [47:0] src_data;
`ifdef FFT_FRAMER_OVF_CNT_EN
   logic [15:0] ovf_count;
`endif
   int errors = 0, checks = 0;
   logic [47:0] got_data[$];
   bit got_sop[$], got_eop[$];
   int unstable, gaps;
   bit timeout;

   fft_sink_framer #(.DEPTH(16), .ADC_W(12)) dut (
      .clock50(clk), .reset_n(rst_n), .enable(enable), .fftpts_cfg(fftpts_cfg),
      .inverse_cfg(inverse_cfg), .adc_valid(adc_valid), .adc_data(adc_data),
      .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
      .src_error(src_error), .src_data(src_data), .overflow(overflow), .clr_ovf(clr_ovf),
      .cfg_err(cfg_err), .busy(busy)
`ifdef FFT_FRAMER_OVF_CNT_EN
      , .ovf_count(ovf_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] exp_beat(input logic [11:0] s, input logic [10:0] n, input logic inv);
      return {s ^ 12'h800, 6'b0, 18'b0, n, inv};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] d);
      adc_valid = 1'b1;
      adc_data = d;
      tick;
      adc_valid = 1'b0;
   endtask

   task automatic pulse_reset;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   // observes one packet; no judgement here, the callers compare
   task automatic recv_packet(input bit stall, input int max_beats, input int chg_beat);
      logic [49:0] hold;
      bit held, started, done;
      got_data.delete();
      got_sop.delete();
      got_eop.delete();
      unstable = 0; gaps = 0; timeout = 1; held = 0; started = 0; done = 0; hold = '0;
      for (int c = 0; c < 200 && !done; c++) begin
         src_ready = stall ? c[0] : 1'b1;
         if (got_data.size() == chg_beat) fftpts_cfg = 11'd16;
         if (src_valid) begin
            started = 1;
            if (held && {src_data, src_sop, src_eop} !== hold) unstable++;
            held = !src_ready;
            hold = {src_data, src_sop, src_eop};
            if (src_ready) begin
               got_data.push_back(src_data);
               got_sop.push_back(src_sop);
               got_eop.push_back(src_eop);
               done = src_eop || got_data.size() == max_beats;
               if (done) timeout = 0;
            end
         end else if (started) gaps++;
         tick;
      end
      src_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      checks++; if ({src_valid, src_sop, src_eop, busy, overflow, cfg_err} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {src_valid, src_sop, src_eop, busy, overflow, cfg_err}); end
      checks++; if (src_data !== 48'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", src_data); end
      checks++; if (src_error !== 2'b00) begin errors++; $display("FAIL reset_error: got %b expected 00", src_error); end
      checks++; if (dut.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", dut.level); end
`ifdef FFT_FRAMER_OVF_CNT_EN
      checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
`endif
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      enable = 1'b1; fftpts_cfg = 11'd8; inverse_cfg = 1'b1;
      for (int i = 0; i < 8; i++) push(12'h800 + 12'(i));
      checks++; if (src_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got valid=%b expected 0", src_valid); end
      tick;
      checks++; if ({src_valid, src_sop} !== 2'b11) begin errors++; $display("FAIL basic_latency: got valid/sop=%b expected 11", {src_valid, src_sop}); end
      recv_packet(0, 100, -1);
      checks++; if (timeout !== 1'b0 || got_data.size() != 8) begin errors++; $display("FAIL basic_beats: got %0d beats timeout=%b expected 8", got_data.size(), timeout); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)); end
         checks++; if ({got_sop[k], got_eop[k]} !== {k == 0, k == 7}) begin errors++; $display("FAIL basic_sop_eop[%0d]: got %b%b expected %b%b", k, got_sop[k], got_eop[k], k == 0, k == 7); end
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL basic_gaps: got %0d expected 0", gaps); end
      checks++; if ({src_valid, busy} !== 2'b00 || dut.level !== 5'd0) begin errors++; $display("FAIL basic_after: got valid/busy=%b level=%0d expected 00 level 0", {src_valid, busy}, dut.level); end
      enable = 1'b0;
   endtask

   task automatic test_stall;
      enable = 1'b0; fftpts_cfg = 11'd8; inverse_cfg = 1'b1;
      for (int i = 0; i < 8; i++) push(12'h800 + 12'(i));
      enable = 1'b1;
      recv_packet(1, 100, -1);
      enable = 1'b0;
      checks++; if (timeout !== 1'b0 || got_data.size() != 8) begin errors++; $display("FAIL stall_beats: got %0d beats timeout=%b expected 8", got_data.size(), timeout); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)); end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL stall_hold: got %0d changes while stalled expected 0", unstable); end
      checks++; if (got_data.size() == 8 && {got_sop[0], got_eop[7]} !== 2'b11) begin errors++; $display("FAIL stall_sop_eop: got %b%b expected 11", got_sop[0], got_eop[7]); end
   endtask

   task automatic test_back_to_back;
      enable = 1'b0; fftpts_cfg = 11'd8; inverse_cfg = 1'b0;
      for (int i = 0; i < 16; i++) push(12'h800 + 12'(i));
      enable = 1'b1;
      recv_packet(0, 100, -1);
      checks++; if (src_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got valid=%b expected 0", src_valid); end
      tick;
      checks++; if ({src_valid, src_sop} !== 2'b11) begin errors++; $display("FAIL b2b_restart: got valid/sop=%b expected 11", {src_valid, src_sop}); end
      recv_packet(0, 100, -1);
      enable = 1'b0;
      checks++; if (got_data.size() != 8) begin errors++; $display("FAIL b2b_beats: got %0d expected 8", got_data.size()); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(12'h808 + 12'(k), 11'd8, 1'b0)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(12'h808 + 12'(k), 11'd8, 1'b0)); end
      end
   endtask

   task automatic test_cfg_change;
      enable = 1'b0; fftpts_cfg = 11'd8; inverse_cfg = 1'b1;
      for (int i = 0; i < 16; i++) push(12'h800 + 12'(i));
      enable = 1'b1;
      recv_packet(0, 100, 2);
      checks++; if (got_data.size() != 8) begin errors++; $display("FAIL chg_first_beats: got %0d expected 8", got_data.size()); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)) begin errors++; $display("FAIL chg_first_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(12'h800 + 12'(k), 11'd8, 1'b1)); end
      end
      checks++; if (dut.level !== 5'd8 || src_valid !== 1'b0) begin errors++; $display("FAIL chg_wait: got level=%0d valid=%b expected 8 and 0", dut.level, src_valid); end
      for (int i = 0; i < 8; i++) push(12'h810 + 12'(i));
      recv_packet(0, 100, -1);
      enable = 1'b0;
      checks++; if (timeout !== 1'b0 || got_data.size() != 16) begin errors++; $display("FAIL chg_second_beats: got %0d timeout=%b expected 16", got_data.size(), timeout); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(12'h808 + 12'(k), 11'd16, 1'b1)) begin errors++; $display("FAIL chg_second_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(12'h808 + 12'(k), 11'd16, 1'b1)); end
      end
      fftpts_cfg = 11'd8;
   endtask

   task automatic test_overflow;
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         push(12'h100 + 12'(i));
         if (i == 15) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_16: got %b expected 0", overflow); end end
         if (i == 16) begin checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_at_17: got %b expected 1", overflow); end end
      end
      checks++; if (dut.level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", dut.level); end
`ifdef FFT_FRAMER_OVF_CNT_EN
      checks++; if (ovf_count !== 16'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", ovf_count); end
`endif
      clr_ovf = 1'b1;
      tick;
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
`ifdef FFT_FRAMER_OVF_CNT_EN
      checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL ovf_count_clear: got %0d expected 0", ovf_count); end
`endif
      clr_ovf = 1'b1;
      push(12'h555);
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_priority: got %b expected 1", overflow); end
      pulse_reset;
      checks++; if (overflow !== 1'b0 || dut.level !== 5'd0) begin errors++; $display("FAIL ovf_reset: got ovf=%b level=%0d expected 0 0", overflow, dut.level); end
   endtask

   task automatic test_cfg_err;
      logic [10:0] v[7] = '{11'd4, 11'd8, 11'd12, 11'd16, 11'd32, 11'd0, 11'd1024};
      logic e[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int seen;
      enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         fftpts_cfg = v[i];
         tick;
         checks++; if (cfg_err !== e[i]) begin errors++; $display("FAIL cfg_err[%0d]: got %b expected %b", v[i], cfg_err, e[i]); end
      end
      fftpts_cfg = 11'd12;
      for (int i = 0; i < 16; i++) push(12'h200 + 12'(i));
      enable = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (src_valid) seen++;
         tick;
      end
      checks++; if (cfg_err !== 1'b1 || seen != 0) begin errors++; $display("FAIL cfg_err_block: got cfg_err=%b valid_cycles=%0d expected 1 and 0", cfg_err, seen); end
      enable = 1'b0;
      fftpts_cfg = 11'd8;
      pulse_reset;
   endtask

   task automatic test_reset_mid;
      logic [11:0] s[8], t[8];
      for (int i = 0; i < 8; i++) begin
         s[i] = 12'(i * 291 + 240);
         t[i] = 12'(i * 499 + 7);
      end
      enable = 1'b1; fftpts_cfg = 11'd8; inverse_cfg = 1'b0;
      for (int i = 0; i < 8; i++) push(s[i]);
      recv_packet(0, 4, -1);
      checks++; if (got_data.size() != 4) begin errors++; $display("FAIL rmid_pre_beats: got %0d expected 4", got_data.size()); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(s[k], 11'd8, 1'b0)) begin errors++; $display("FAIL rmid_pre_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(s[k], 11'd8, 1'b0)); end
      end
      rst_n = 1'b0;
      #1;
      checks++; if ({src_valid, src_eop, busy} !== 3'b000 || dut.level !== 5'd0) begin errors++; $display("FAIL rmid_abort: got valid/eop/busy=%b level=%0d expected 000 0", {src_valid, src_eop, busy}, dut.level); end
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) push(t[i]);
      recv_packet(0, 100, -1);
      enable = 1'b0;
      checks++; if (timeout !== 1'b0 || got_data.size() != 8) begin errors++; $display("FAIL rmid_new_beats: got %0d timeout=%b expected 8", got_data.size(), timeout); end
      checks++; if (got_data.size() == 8 && {got_sop[0], got_eop[7]} !== 2'b11) begin errors++; $display("FAIL rmid_new_sop_eop: got %b%b expected 11", got_sop[0], got_eop[7]); end
      for (int k = 0; k < got_data.size(); k++) begin
         checks++; if (got_data[k] !== exp_beat(t[k], 11'd8, 1'b0)) begin errors++; $display("FAIL rmid_new_data[%0d]: got %h expected %h", k, got_data[k], exp_beat(t[k], 11'd8, 1'b0)); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall;
      test_back_to_back;
      test_cfg_change;
      test_overflow;
      test_cfg_err;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
